// File: rtl/cpld_uart_pkg.sv
// Shared types and 50 MHz timing defaults for the CPLD UART transmit path.
package cpld_uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    WR_LOW    = 3'd2,
    WR_HIGH   = 3'd3,
    WAIT_TBRE = 3'd4,
    WAIT_TSRE = 3'd5
  } state_t;

  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int DEF_SETUP_CYC    = 1;
  localparam int DEF_WR_PULSE_CYC = 2;      // 40 ns at 50 MHz
  localparam int DEF_TIMEOUT_CYC  = 500000; // 10 ms at 50 MHz

endpackage

// File: rtl/cpld_uart_tx_if.sv
// SoC byte handshake plus CPLD/BaseRAM bus pins of the UART transmit path.
interface cpld_uart_tx_if #(
  parameter int FIFO_DEPTH = cpld_uart_pkg::DEF_FIFO_DEPTH
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          uart_wrn;
  logic          uart_rdn;
  logic          uart_tbre;
  logic          uart_tsre;
  logic [7:0]    bus_data;
  logic          bus_oe;
  logic          bus_busy;
  logic [LW-1:0] fifo_level;
  logic          err_timeout;
  logic          err_clr;

  modport master (
    output tx_data, tx_valid, uart_tbre, uart_tsre, err_clr,
    input  tx_ready, uart_wrn, uart_rdn, bus_data, bus_oe, bus_busy,
           fifo_level, err_timeout
  );

  modport slave (
    input  tx_data, tx_valid, uart_tbre, uart_tsre, err_clr,
    output tx_ready, uart_wrn, uart_rdn, bus_data, bus_oe, bus_busy,
           fifo_level, err_timeout
  );

endinterface

// File: rtl/cpld_uart_tx_sync_fifo.sv
// Small first-word-fall-through byte FIFO; the head entry is visible on pop_data.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (level_reg == (AW+1)'(DEPTH));
  assign empty    = (level_reg == '0);
  assign level    = level_reg;
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr_reg];

  // Storage carries no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/cpld_uart_tx.sv
// CPLD UART transmit path: buffers SoC bytes and runs the BaseRAM-bus write strobe protocol.
// All bus pins are decoded from the state register and then registered once more.
module cpld_uart_tx
  import cpld_uart_pkg::*;
#(
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int SETUP_CYC    = DEF_SETUP_CYC,
  parameter int WR_PULSE_CYC = DEF_WR_PULSE_CYC,
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
  input logic           clk,
  input logic           reset,
  cpld_uart_tx_if.slave io
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] SETUP_LAST   = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LAST   = CW'(WR_PULSE_CYC - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);

  state_t        state_reg;
  state_t        state_next;
  logic [CW-1:0] cnt_reg;
  logic          tbre_meta_reg;
  logic          tsre_meta_reg;
  logic          sync_tbre;
  logic          sync_tsre;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;
  logic          timeout_hit;
  logic          wrn_reg;
  logic          oe_reg;
  logic          busy_reg;
  logic [7:0]    data_reg;
  logic          err_reg;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (io.tx_valid),
    .push_data (io.tx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (io.fifo_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tbre_meta_reg <= 1'b0;
      sync_tbre     <= 1'b0;
      tsre_meta_reg <= 1'b0;
      sync_tsre     <= 1'b0;
    end else begin
      tbre_meta_reg <= io.uart_tbre;
      sync_tbre     <= tbre_meta_reg;
      tsre_meta_reg <= io.uart_tsre;
      sync_tsre     <= tsre_meta_reg;
    end
  end

  always_comb begin
    state_next  = state_reg;
    fifo_pop    = 1'b0;
    timeout_hit = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP:   if (cnt_reg == SETUP_LAST) state_next = WR_LOW;
      WR_LOW:  if (cnt_reg == PULSE_LAST) state_next = WR_HIGH;
      WR_HIGH: state_next = WAIT_TBRE;
      WAIT_TBRE: begin
        if (sync_tbre) begin
          state_next = WAIT_TSRE;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      WAIT_TSRE: begin
        if (sync_tsre) begin
          state_next = IDLE;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One counter times every phase; it restarts on each state change and idles at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_next != state_reg || state_reg == IDLE) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrn_reg  <= 1'b1;
      oe_reg   <= 1'b0;
      busy_reg <= 1'b0;
      data_reg <= 8'h00;
      err_reg  <= 1'b0;
    end else begin
      wrn_reg  <= (state_reg != WR_LOW);
      oe_reg   <= (state_reg == SETUP) || (state_reg == WR_LOW) || (state_reg == WR_HIGH);
      busy_reg <= (state_reg == SETUP) || (state_reg == WR_LOW) || (state_reg == WR_HIGH);
      if (fifo_pop) begin
        data_reg <= fifo_head;
      end
      // A clear request wins over a timeout landing in the same cycle.
      if (io.err_clr) begin
        err_reg <= 1'b0;
      end else if (timeout_hit) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign io.tx_ready    = ~fifo_full;
  assign io.uart_wrn    = wrn_reg;
  assign io.uart_rdn    = 1'b1;
  assign io.bus_data    = data_reg;
  assign io.bus_oe      = oe_reg;
  assign io.bus_busy    = busy_reg;
  assign io.err_timeout = err_reg;

endmodule

// File: tb/tb_cpld_uart_tx.sv
// Directed bench for cpld_uart_tx: a main instance (long timeout) and a short-timeout instance.
module tb_cpld_uart_tx;

  logic clk = 1'b0;
  logic reset;
  logic reset2;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpld_uart_tx_if #(.FIFO_DEPTH(4)) m ();
  cpld_uart_tx_if #(.FIFO_DEPTH(4)) t ();

  cpld_uart_tx #(
    .FIFO_DEPTH(4), .SETUP_CYC(1), .WR_PULSE_CYC(2), .TIMEOUT_CYC(1000)
  ) dut (
    .clk(clk), .reset(reset), .io(m)
  );

  cpld_uart_tx #(
    .FIFO_DEPTH(4), .SETUP_CYC(1), .WR_PULSE_CYC(2), .TIMEOUT_CYC(50)
  ) dut_to (
    .clk(clk), .reset(reset2), .io(t)
  );

  // Strobe recorders: cycle of each uart_wrn edge, byte on the bus, and bus state one sample earlier.
  int         m_fall[$], m_rise[$], t_fall[$], t_rise[$], t_err_rise[$];
  logic [7:0] m_data[$], m_data_before[$], t_data[$];
  logic       m_oe_before[$];
  logic       m_prev_wrn = 1'b1, m_prev_oe = 1'b0, t_prev_wrn = 1'b1, t_prev_err = 1'b0;
  logic [7:0] m_prev_data = 8'h00;

  always @(negedge clk) begin
    if (m_prev_wrn && !m.uart_wrn) begin
      m_fall.push_back(cyc);
      m_data.push_back(m.bus_data);
      m_data_before.push_back(m_prev_data);
      m_oe_before.push_back(m_prev_oe);
      $display("dut    strobe data=%02h cycle=%0d", m.bus_data, cyc);
    end
    if (!m_prev_wrn && m.uart_wrn) m_rise.push_back(cyc);
    m_prev_wrn  = m.uart_wrn;
    m_prev_oe   = m.bus_oe;
    m_prev_data = m.bus_data;
  end

  always @(negedge clk) begin
    if (t_prev_wrn && !t.uart_wrn) begin
      t_fall.push_back(cyc);
      t_data.push_back(t.bus_data);
      $display("dut_to strobe data=%02h cycle=%0d", t.bus_data, cyc);
    end
    if (!t_prev_wrn && t.uart_wrn) t_rise.push_back(cyc);
    if (!t_prev_err && t.err_timeout) t_err_rise.push_back(cyc);
    t_prev_wrn = t.uart_wrn;
    t_prev_err = t.err_timeout;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_m(input logic [7:0] d, output int pc);
    m.tx_data = d; m.tx_valid = 1'b1;
    @(posedge clk); #1;
    m.tx_valid = 1'b0; pc = cyc;
  endtask

  task automatic push_t(input logic [7:0] d, output int pc);
    t.tx_data = d; t.tx_valid = 1'b1;
    @(posedge clk); #1;
    t.tx_valid = 1'b0; pc = cyc;
  endtask

  task automatic wait_m_falls(input int n, input int budget, output bit ok);
    int g = 0;
    while (m_fall.size() < n && g < budget) begin tick(1); g++; end
    ok = (m_fall.size() >= n);
  endtask

  task automatic wait_t_falls(input int n, input int budget, output bit ok);
    int g = 0;
    while (t_fall.size() < n && g < budget) begin tick(1); g++; end
    ok = (t_fall.size() >= n);
  endtask

  task automatic test_reset;
    reset = 1'b1; reset2 = 1'b1;
    m.tx_data = 8'h00; m.tx_valid = 1'b0; m.uart_tbre = 1'b1; m.uart_tsre = 1'b1; m.err_clr = 1'b0;
    t.tx_data = 8'h00; t.tx_valid = 1'b0; t.uart_tbre = 1'b1; t.uart_tsre = 1'b1; t.err_clr = 1'b0;
    tick(3);
    @(negedge clk);
    checks++; if (m.uart_wrn !== 1'b1)    begin errors++; $display("FAIL reset_wrn: got %b want 1", m.uart_wrn); end
    checks++; if (m.uart_rdn !== 1'b1)    begin errors++; $display("FAIL reset_rdn: got %b want 1", m.uart_rdn); end
    checks++; if (m.bus_oe !== 1'b0)      begin errors++; $display("FAIL reset_oe: got %b want 0", m.bus_oe); end
    checks++; if (m.bus_busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", m.bus_busy); end
    checks++; if (m.bus_data !== 8'h00)   begin errors++; $display("FAIL reset_data: got %02h want 00", m.bus_data); end
    checks++; if (m.fifo_level !== 3'd0)  begin errors++; $display("FAIL reset_level: got %0d want 0", m.fifo_level); end
    checks++; if (m.tx_ready !== 1'b1)    begin errors++; $display("FAIL reset_ready: got %b want 1", m.tx_ready); end
    checks++; if (m.err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", m.err_timeout); end
    reset = 1'b0; reset2 = 1'b0;
    tick(3);
  endtask

  task automatic test_single_byte;
    int n0, pc, viol;
    bit ok;
    m.uart_tbre = 1'b0; m.uart_tsre = 1'b0;
    tick(3);
    n0 = m_fall.size();
    push_m(8'h41, pc);
    wait_m_falls(n0 + 1, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_strobe: got 0 strobes want 1"); end
    else begin
      checks++; if (m_fall[n0] - pc !== 3) begin errors++; $display("FAIL single_latency: got %0d want 3", m_fall[n0] - pc); end
      checks++; if (m_data_before[n0] !== 8'h41) begin errors++; $display("FAIL single_setup_data: got %02h want 41", m_data_before[n0]); end
      checks++; if (m_oe_before[n0] !== 1'b1) begin errors++; $display("FAIL single_setup_oe: got %b want 1", m_oe_before[n0]); end
    end
    // From here the FSM sits in WAIT_TBRE, so the bus must be released.
    tick(4);
    viol = 0;
    repeat (6) begin
      @(negedge clk);
      if (m.bus_busy !== 1'b0 || m.bus_oe !== 1'b0) viol++;
      @(posedge clk); #1;
    end
    checks++; if (viol !== 0) begin errors++; $display("FAIL single_busy_wait: got %0d busy samples want 0", viol); end
    checks++; if (m_rise.size() <= n0) begin errors++; $display("FAIL single_rise: got no rising edge want 1"); end
    else begin
      checks++; if (m_rise[n0] - m_fall[n0] !== 2) begin errors++; $display("FAIL single_width: got %0d want 2", m_rise[n0] - m_fall[n0]); end
    end
    m.uart_tbre = 1'b1; m.uart_tsre = 1'b1;
    tick(10);
    // Back in IDLE: a fresh push must see the same 3-cycle latency.
    push_m(8'h42, pc);
    wait_m_falls(n0 + 2, 20, ok);
    checks++; if (!ok || m_fall[n0 + 1] - pc !== 3) begin errors++; $display("FAIL single_idle_return: got ok=%b want latency 3", ok); end
    tick(15);
  endtask

  task automatic test_burst;
    int n0, i, stall_at, guard;
    logic [2:0] lvl;
    bit ok, rdy;
    m.uart_tbre = 1'b0; m.uart_tsre = 1'b0;
    tick(3);
    n0 = m_fall.size(); i = 0; stall_at = -1; lvl = 3'd0; guard = 0;
    m.tx_valid = 1'b1;
    while (i < 6 && stall_at < 0 && guard < 20) begin
      m.tx_data = 8'(i + 1);
      rdy = m.tx_ready;
      if (!rdy) begin
        stall_at = i; lvl = m.fifo_level;
      end else begin
        tick(1); i++;
      end
      guard++;
    end
    // Byte 1 is popped straight into the transmitter, so bytes 2..5 fill the FIFO and byte 6 stalls.
    checks++; if (stall_at !== 5) begin errors++; $display("FAIL burst_stall_index: got %0d want 5", stall_at); end
    checks++; if (lvl !== 3'd4) begin errors++; $display("FAIL burst_level_full: got %0d want 4", lvl); end
    tick(30);
    checks++; if (m_fall.size() !== n0 + 1) begin errors++; $display("FAIL burst_busy_hold: got %0d strobes want 1", m_fall.size() - n0); end
    m.uart_tbre = 1'b1;
    tick(20);
    checks++; if (m_fall.size() !== n0 + 1) begin errors++; $display("FAIL burst_tsre_gate: got %0d strobes want 1", m_fall.size() - n0); end
    m.uart_tsre = 1'b1;
    guard = 0;
    while (i < 6 && guard < 100) begin
      rdy = m.tx_ready;
      tick(1);
      if (rdy) i++;
      guard++;
    end
    m.tx_valid = 1'b0;
    checks++; if (i !== 6) begin errors++; $display("FAIL burst_accept: got %0d bytes want 6", i); end
    wait_m_falls(n0 + 6, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL burst_count: got %0d strobes want 6", m_fall.size() - n0); end
    else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (m_data[n0 + k] !== 8'(k + 1)) begin errors++; $display("FAIL burst_order[%0d]: got %02h want %02h", k, m_data[n0 + k], 8'(k + 1)); end
      end
    end
    tick(10);
  endtask

  task automatic test_handshake;
    int n0, pc, c0;
    bit ok;
    m.uart_tbre = 1'b0; m.uart_tsre = 1'b0;
    tick(3);
    n0 = m_fall.size();
    push_m(8'h77, pc);
    push_m(8'h78, pc);
    wait_m_falls(n0 + 1, 20, ok);
    tick(100);
    checks++; if (m_fall.size() !== n0 + 1) begin errors++; $display("FAIL hs_gate: got %0d strobes want 1", m_fall.size() - n0); end
    m.uart_tbre = 1'b1; m.uart_tsre = 1'b1;
    c0 = cyc;
    // 2 sync flops, WAIT_TBRE, WAIT_TSRE, IDLE pop, SETUP, then registered WR_LOW: strobe 7 edges on.
    wait_m_falls(n0 + 2, 30, ok);
    checks++; if (!ok || m_fall[n0 + 1] - c0 !== 7) begin errors++; $display("FAIL hs_release_latency: got ok=%b want 7 cycles", ok); end
    else begin
      checks++; if (m_data[n0 + 1] !== 8'h78) begin errors++; $display("FAIL hs_data: got %02h want 78", m_data[n0 + 1]); end
    end
    tick(15);
  endtask

  task automatic test_timeout;
    int n0, e0, pc, r, guard;
    bit ok;
    n0 = t_fall.size(); e0 = t_err_rise.size();
    t.uart_tbre = 1'b0; t.uart_tsre = 1'b0;
    tick(3);
    push_t(8'hA5, pc);
    push_t(8'h5A, pc);
    guard = 0;
    while (t_err_rise.size() <= e0 && guard < 100) begin tick(1); guard++; end
    checks++;
    if (t_err_rise.size() <= e0 || t_rise.size() <= n0) begin errors++; $display("FAIL to_rise: got no err_timeout want 1"); end
    else begin
      checks++; if (t_err_rise[e0] - t_rise[n0] !== 50) begin errors++; $display("FAIL to_delay: got %0d want 50", t_err_rise[e0] - t_rise[n0]); end
    end
    wait_t_falls(n0 + 2, 30, ok);
    checks++; if (!ok || t_data[n0 + 1] !== 8'h5A) begin errors++; $display("FAIL to_next_byte: got ok=%b want 5a sent", ok); end
    checks++; if (t.err_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", t.err_timeout); end
    t.err_clr = 1'b1; tick(1); t.err_clr = 1'b0;
    @(negedge clk);
    checks++; if (t.err_timeout !== 1'b0) begin errors++; $display("FAIL to_clear: got %b want 0", t.err_timeout); end
    guard = 0;
    while (t_rise.size() < n0 + 2 && guard < 30) begin tick(1); guard++; end
    r = (t_rise.size() >= n0 + 2) ? t_rise[n0 + 1] : cyc;
    // Hold err_clr across the second timeout edge: the clear must win.
    t.err_clr = 1'b1;
    guard = 0;
    while (cyc < r + 50 && guard < 100) begin tick(1); guard++; end
    checks++; if (t.err_timeout !== 1'b0) begin errors++; $display("FAIL to_clr_priority: got %b want 0", t.err_timeout); end
    t.err_clr = 1'b0;
    tick(3);
    checks++; if (t.err_timeout !== 1'b0) begin errors++; $display("FAIL to_after_clr: got %b want 0", t.err_timeout); end
  endtask

  task automatic test_reset_mid;
    int n0, pc, guard;
    m.uart_tbre = 1'b0; m.uart_tsre = 1'b0;
    tick(3);
    n0 = m_fall.size();
    push_m(8'h99, pc);
    push_m(8'h9A, pc);
    push_m(8'h9B, pc);
    guard = 0;
    @(negedge clk);
    while (m.uart_wrn !== 1'b0 && guard < 30) begin @(negedge clk); guard++; end
    #2 reset = 1'b1;
    #1;
    checks++; if (m.uart_wrn !== 1'b1)   begin errors++; $display("FAIL rst_mid_wrn: got %b want 1", m.uart_wrn); end
    checks++; if (m.bus_oe !== 1'b0)     begin errors++; $display("FAIL rst_mid_oe: got %b want 0", m.bus_oe); end
    checks++; if (m.fifo_level !== 3'd0) begin errors++; $display("FAIL rst_mid_level: got %0d want 0", m.fifo_level); end
    @(negedge clk);
    reset = 1'b0;
    m.uart_tbre = 1'b1; m.uart_tsre = 1'b1;
    tick(30);
    checks++; if (m_fall.size() !== n0 + 1) begin errors++; $display("FAIL rst_mid_no_strobe: got %0d strobes want 1", m_fall.size() - n0); end
  endtask

  task automatic test_push_pop;
    int n0, pc;
    bit ok;
    m.uart_tbre = 1'b1; m.uart_tsre = 1'b0;
    tick(3);
    n0 = m_fall.size();
    push_m(8'h11, pc);
    wait_m_falls(n0 + 1, 20, ok);
    push_m(8'h22, pc);
    push_m(8'h33, pc);
    tick(5);
    checks++; if (m.fifo_level !== 3'd2) begin errors++; $display("FAIL pp_level_before: got %0d want 2", m.fifo_level); end
    // tsre set after edge F0: sync at F2, WAIT_TSRE->IDLE at F3, pop at F4 coincides with the push.
    m.uart_tsre = 1'b1;
    tick(3);
    m.tx_data = 8'h44; m.tx_valid = 1'b1;
    tick(1);
    m.tx_valid = 1'b0;
    checks++; if (m.fifo_level !== 3'd2) begin errors++; $display("FAIL pp_level_after: got %0d want 2", m.fifo_level); end
    wait_m_falls(n0 + 4, 60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL pp_count: got %0d strobes want 4", m_fall.size() - n0); end
    else if (m_data[n0 + 1] !== 8'h22 || m_data[n0 + 2] !== 8'h33 || m_data[n0 + 3] !== 8'h44) begin
      errors++;
      $display("FAIL pp_order: got %02h %02h %02h want 22 33 44", m_data[n0 + 1], m_data[n0 + 2], m_data[n0 + 3]);
    end
    tick(10);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_handshake();
    test_timeout();
    test_reset_mid();
    test_push_pop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
